// File: rtl/audio_pkg.sv
// Shared types and defaults for the sample playback arbiter: FSM state encoding,
// default bus widths and the index-width helper used to size requester indices.
package audio_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_PLAY  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam int ADDR_W_DEF   = 20;
   localparam int SAMPLE_W_DEF = 10;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// The pointer register lives in the parent.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     onehot,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   always_comb begin
      int j;
      onehot = '0;
      idx    = '0;
      found  = 1'b0;
      j      = 0;
      for (int i = 0; i < N; i++) begin
         j = (int'(ptr) + i) % N;
         if (!found && req[j]) begin
            found     = 1'b1;
            onehot[j] = 1'b1;
            idx       = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/sample_playback_arbiter.sv
// Round-robin owner of the sample ROM and audio-out write port: streams one track
// per key press, with hold-to-play, optional looping and release abort.
module sample_playback_arbiter
   import audio_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int SAMPLE_W = SAMPLE_W_DEF
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        loop_en,
   input  logic [NUM_REQ*ADDR_W-1:0] track_base,
   input  logic [NUM_REQ*ADDR_W-1:0] track_last,
   input  logic [SAMPLE_W-1:0]       rom_data,
   input  logic                      audio_out_allowed,
   output logic [ADDR_W-1:0]         rom_address,
   output logic [SAMPLE_W-1:0]       audio_out,
   output logic                      write_audio_out,
   output logic [NUM_REQ-1:0]        grant,
   output logic                      busy,
   output logic                      done,
   output logic                      clear_buffer,
   output state_t                    fsm_state
);

   localparam int IDX_W = idx_width(NUM_REQ);

   // Handshake: a sample is transferred in exactly the cycle where
   // write_audio_out=1, which only happens while audio_out_allowed=1.
   state_t               state_q, state_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [IDX_W-1:0]     ptr_q, ptr_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic                 write_c, done_c;

   logic [NUM_REQ-1:0]   pick_onehot;
   logic [IDX_W-1:0]     pick_idx;
   logic                 pick_found;
   logic [ADDR_W-1:0]    pick_base, cur_base, cur_last;
   logic                 cur_req, cur_loop, at_end;

   rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr (
      .req    (req),
      .ptr    (ptr_q),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .found  (pick_found)
   );

   assign pick_base = track_base[int'(pick_idx)*ADDR_W +: ADDR_W];
   assign cur_base  = track_base[int'(idx_q)*ADDR_W +: ADDR_W];
   assign cur_last  = track_last[int'(idx_q)*ADDR_W +: ADDR_W];
   assign cur_req   = req[idx_q];
   assign cur_loop  = loop_en[idx_q];
   // >= rather than == so last<base still ends after one sample and the
   // address can never run past the top of the ROM.
   assign at_end    = (addr_q >= cur_last);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         idx_q   <= '0;
         ptr_q   <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         addr_q  <= addr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      addr_d  = addr_q;
      write_c = 1'b0;
      done_c  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (pick_found) begin
               grant_d = pick_onehot;
               idx_d   = pick_idx;
               addr_d  = pick_base;
               ptr_d   = (pick_idx == IDX_W'(NUM_REQ-1)) ? '0 : pick_idx + IDX_W'(1);
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            if (!cur_req) begin
               grant_d = '0;
               state_d = S_IDLE;
            end else begin
               state_d = S_PLAY;
            end
         end
         S_PLAY: begin
            // Release wins over a write offered in the same cycle.
            if (!cur_req) begin
               grant_d = '0;
               state_d = S_IDLE;
            end else if (audio_out_allowed) begin
               write_c = 1'b1;
               if (at_end) begin
                  if (cur_loop) begin
                     addr_d  = cur_base;
                     state_d = S_FETCH;
                  end else begin
                     done_c  = 1'b1;
                     state_d = S_DONE;
                  end
               end else begin
                  addr_d  = addr_q + ADDR_W'(1);
                  state_d = S_FETCH;
               end
            end
         end
         S_DONE: begin
            if (!cur_req) begin
               grant_d = '0;
               state_d = S_IDLE;
            end
         end
         default: begin
            grant_d = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   assign write_audio_out = write_c;
   assign audio_out       = write_c ? rom_data : '0;
   assign done            = done_c;
   assign busy            = (state_q != S_IDLE);
   assign clear_buffer    = (state_q == S_IDLE);
   assign grant           = grant_q;
   assign rom_address     = addr_q;
   assign fsm_state       = state_q;

endmodule

// File: doc/sample_playback_arbiter.md
Name: sample_playback_arbiter

Overview:
- Shares the single sample ROM and the audio-out FIFO write port between NUM_REQ key requesters; each requester owns one track, given as a ROM base/last address pair.
- Grants one requester at a time, round-robin.
- Sequences ROM reads (1-cycle read latency) and paces sample writes against the audio-out-allowed handshake.
- Handles hold-to-play, optional looping and release abort.
- Sits between the key-press/debounce logic and the sample ROM plus audio codec interface.

Parameters:
- NUM_REQ, 4, number of requesters/tracks.
- ADDR_W, 20, ROM address width.
- SAMPLE_W, 10, sample width.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  level request per key; held high while the key is pressed.
- loop_en  in  NUM_REQ  per-track loop enable, sampled when that track reaches its end.
- track_base  in  NUM_REQ*ADDR_W  packed first address of each track (track i at bits [i*ADDR_W +: ADDR_W]).
- track_last  in  NUM_REQ*ADDR_W  packed last address of each track.
- rom_data  in  SAMPLE_W  ROM output; valid one cycle after rom_address.
- audio_out_allowed  in  1  FIFO can accept a write this cycle.
- rom_address  out  ADDR_W  registered ROM address.
- audio_out  out  SAMPLE_W  sample to write; 0 when write_audio_out=0.
- write_audio_out  out  1  write strobe; single cycle per sample.
- grant  out  NUM_REQ  one-hot current owner; 0 when idle.
- busy  out  1  high in any state except S_IDLE.
- done  out  1  1-cycle pulse when a non-looping track plays its last sample.
- clear_buffer  out  1  high while in S_IDLE.

Behaviour:
- Reset (synchronous, active-high):
  - Next state is S_IDLE; rom_address=0; grant=0; round-robin pointer=0.
  - write_audio_out=0, done=0, audio_out=0; clear_buffer=1 from the first cycle after reset.
  - Reset mid-track aborts with no further writes.
- States:
  - S_IDLE: clear_buffer=1. If any req bit is set, pick the first set bit at or after the pointer, wrapping. Register grant, load rom_address=track_base[g], set pointer=(g+1) mod NUM_REQ, go to S_FETCH. Grant is registered, so the first rom_address is valid the cycle after leaving S_IDLE.
  - S_FETCH: wait one cycle for ROM data, then go to S_PLAY.
  - S_PLAY:
    - If audio_out_allowed=0: stall; no write, rom_address held.
    - If audio_out_allowed=1: write_audio_out=1 and audio_out=rom_data for exactly one cycle.
    - After a write, if rom_address >= track_last[g] (unsigned): done=1 when loop_en[g]=0. If loop_en[g]=1 and req[g]=1, reload track_base[g] and go to S_FETCH; otherwise go to S_DONE.
    - After a write, if not at the end: rom_address+1, go to S_FETCH.
  - S_DONE: outputs silent, grant held; when req[g]=0, go to S_IDLE.
- Release abort: req[g]=0 in S_FETCH or S_PLAY gives S_IDLE next cycle, with no write in that cycle. Release takes priority over a simultaneous write.
- Throughput: at most one sample per 2 cycles.
- No preemption: other requests wait until the owner releases or finishes.
- A key held in S_DONE does not retrigger.
- Boundaries:
  - base==last: exactly one sample is written.
  - last<base: one sample is written, then end (the >= compare ends the track).
  - rom_address never wraps past 2^ADDR_W-1 because the >= compare terminates the track.
  - Track inputs are sampled live; they must be static while the track is granted.
  - Multiple simultaneous requests are resolved by the round-robin pointer only.

Decomposition:
- audio_pkg: state encoding (S_IDLE, S_FETCH, S_PLAY, S_DONE) and defaults for ADDR_W/SAMPLE_W.
- Sub-module rr_arbiter: combinational NUM_REQ-wide round-robin pick from req plus pointer, giving one-hot and index outputs. The pointer register stays in the parent.

Test Plan:
- Single track, base=100, last=103, audio_out_allowed=1, req[0] held → 4 writes of ROM[100..103], one every 2 cycles; done pulses with the 4th write; S_DONE until release; then clear_buffer=1.
- audio_out_allowed low for 5 cycles in S_PLAY → no write, rom_address stable; the write resumes with the same sample.
- req[1] and req[2] asserted together from reset → grant=0010; after release, with req[2] still high, grant=0100; next contention starts from index 3.
- loop_en[0]=1, base=10, last=11, req held for 10 cycles → sample sequence 10,11,10,11…; no done; release stops writes within 1 cycle.
- Release req[0] mid-track at address 205 → S_IDLE next cycle, no further write, grant=0.
- reset asserted in S_PLAY → next cycle: grant=0, write_audio_out=0, rom_address=0, clear_buffer=1; base==last single-sample track writes exactly one sample.
